// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the streaming convolution engine.
package cnn_pkg;

  // Controller states.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StMac  = 3'd2;
  localparam logic [2:0] StPost = 3'd3;
  localparam logic [2:0] StHold = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  // Counter width for n distinct values; at least one bit so K=1 still has a signal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a signed value to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_slice.sv
// Signed multiply-accumulate: acc <= clr ? a*b : acc + a*b when enabled.
module conv_mac_slice #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q, acc_d;

  assign prod     = a_i * b_i;
  // Size cast of a signed operand sign-extends.
  assign prod_ext = ACC_W'(prod);

  // Next accumulator value: restart on the first tap, otherwise add.
  always_comb begin
    acc_d = acc_q;
    if (en_i) acc_d = clr_i ? prod_ext : acc_q + prod_ext;
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK 2-D convolution over a raster pixel stream, keeping only K rows on chip.
module conv2d_stream_engine
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(K * K),
  localparam int unsigned TapW  = clog2_min1(K * K)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     cfg_relu_en_i,
  input  logic [4:0]               cfg_shift_i,
  input  logic                     k_wr_en_i,
  input  logic [TapW-1:0]          k_wr_addr_i,
  input  logic signed [DATA_W-1:0] k_wr_data_i,
  input  logic                     pix_valid_i,
  output logic                     pix_ready_o,
  input  logic signed [DATA_W-1:0] pix_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [DATA_W-1:0] out_data_o,
  output logic                     out_last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int unsigned OW       = (IMG_W - K) / STRIDE + 1;
  localparam int unsigned OH       = (IMG_H - K) / STRIDE + 1;
  // Rows past this index feed no output; they are consumed but not stored.
  localparam int unsigned RowsKept = (OH - 1) * STRIDE + K;
  localparam int unsigned NumTaps  = K * K;
  localparam int unsigned ColW     = clog2_min1(IMG_W);
  localparam int unsigned RowW     = clog2_min1(IMG_H + 1);
  localparam int unsigned SlotW    = clog2_min1(K);

  logic [2:0]               state_q, state_d;
  logic                     relu_q, relu_d;
  logic [4:0]               shift_q, shift_d;
  logic [ColW-1:0]          pix_col_q, pix_col_d;
  logic [RowW-1:0]          pix_row_q, pix_row_d;
  logic [SlotW-1:0]         wslot_q, wslot_d;
  logic [RowW-1:0]          band_q, band_d;
  logic [SlotW-1:0]         band_slot_q, band_slot_d;
  logic [ColW-1:0]          oc_q, oc_d;
  logic [SlotW-1:0]         kr_q, kr_d;
  logic [SlotW-1:0]         kc_q, kc_d;
  logic [TapW-1:0]          tap_q, tap_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;

  logic signed [DATA_W-1:0] kern_q   [NumTaps];
  logic signed [DATA_W-1:0] rowbuf_q [K][IMG_W];

  logic                     pix_fire, row_end, band_last, col_last;
  logic [RowW-1:0]          load_target;
  logic [SlotW-1:0]         rd_slot;
  logic [ColW-1:0]          rd_col;
  logic                     mac_clr, mac_en;
  logic signed [ACC_W-1:0]  acc, shifted;
  logic signed [DATA_W-1:0] post_val;

  assign pix_ready_o = (state_q == StLoad);
  assign pix_fire    = pix_valid_i & pix_ready_o;
  assign row_end     = (pix_col_q == ColW'(IMG_W - 1));
  assign band_last   = (band_q == RowW'(OH - 1));
  assign col_last    = (oc_q == ColW'(OW - 1));
  // The last band also drains trailing rows so the whole frame is consumed.
  assign load_target = band_last ? RowW'(IMG_H) : RowW'(32'(band_q) * STRIDE + K);

  // Buffer slot and column of the current tap inside the current window.
  always_comb begin
    int unsigned s;
    s = 32'(band_slot_q) + 32'(kr_q);
    if (s >= K) s = s - K;
    rd_slot = SlotW'(s);
    rd_col  = ColW'(32'(oc_q) * STRIDE + 32'(kc_q));
  end

  conv_mac_slice #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .a_i    (rowbuf_q[rd_slot][rd_col]),
    .b_i    (kern_q[tap_q]),
    .acc_o  (acc)
  );

  // Requantise: shift, optional ReLU, saturate to the output width.
  always_comb begin
    shifted = acc >>> shift_q;
    if (relu_q && shifted[ACC_W-1]) shifted = '0;
    post_val = DATA_W'(sat_signed(64'(shifted), DATA_W));
  end

  // Controller next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    relu_d      = relu_q;
    shift_d     = shift_q;
    pix_col_d   = pix_col_q;
    pix_row_d   = pix_row_q;
    wslot_d     = wslot_q;
    band_d      = band_q;
    band_slot_d = band_slot_q;
    oc_d        = oc_q;
    kr_d        = kr_q;
    kc_d        = kc_q;
    tap_d       = tap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    mac_clr     = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StLoad;
          relu_d      = cfg_relu_en_i;
          shift_d     = cfg_shift_i;
          busy_d      = 1'b1;
          pix_col_d   = '0;
          pix_row_d   = '0;
          wslot_d     = '0;
          band_d      = '0;
          band_slot_d = '0;
          oc_d        = '0;
        end
      end
      StLoad: begin
        if (pix_fire) begin
          if (row_end) begin
            pix_col_d = '0;
            pix_row_d = pix_row_q + RowW'(1);
            wslot_d   = (wslot_q == SlotW'(K - 1)) ? '0 : wslot_q + SlotW'(1);
            if ((pix_row_q + RowW'(1)) == load_target) begin
              state_d = StMac;
              kr_d    = '0;
              kc_d    = '0;
              tap_d   = '0;
            end
          end else begin
            pix_col_d = pix_col_q + ColW'(1);
          end
        end
      end
      StMac: begin
        mac_en  = 1'b1;
        mac_clr = (tap_q == '0);
        tap_d   = tap_q + TapW'(1);
        if (kc_q == SlotW'(K - 1)) begin
          kc_d = '0;
          kr_d = kr_q + SlotW'(1);
        end else begin
          kc_d = kc_q + SlotW'(1);
        end
        if (tap_q == TapW'(NumTaps - 1)) state_d = StPost;
      end
      StPost: begin
        out_data_d  = post_val;
        out_valid_d = 1'b1;
        out_last_d  = col_last & band_last;
        state_d     = StHold;
      end
      StHold: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (!col_last) begin
            oc_d    = oc_q + ColW'(1);
            kr_d    = '0;
            kc_d    = '0;
            tap_d   = '0;
            state_d = StMac;
          end else begin
            oc_d = '0;
            if (band_last) begin
              state_d = StDone;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              band_d      = band_q + RowW'(1);
              band_slot_d = SlotW'((32'(band_slot_q) + STRIDE) % K);
              state_d     = StLoad;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Controller, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      pix_col_q   <= '0;
      pix_row_q   <= '0;
      wslot_q     <= '0;
      band_q      <= '0;
      band_slot_q <= '0;
      oc_q        <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      relu_q      <= relu_d;
      shift_q     <= shift_d;
      pix_col_q   <= pix_col_d;
      pix_row_q   <= pix_row_d;
      wslot_q     <= wslot_d;
      band_q      <= band_d;
      band_slot_q <= band_slot_d;
      oc_q        <= oc_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      tap_q       <= tap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Kernel taps are writable only while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumTaps; i++) kern_q[i] <= '0;
    end else if (state_q == StIdle && k_wr_en_i && 32'(k_wr_addr_i) < NumTaps) begin
      kern_q[k_wr_addr_i] <= k_wr_data_i;
    end
  end

  // Circular row buffer; no reset since every slot is written before it is read.
  always_ff @(posedge clk_i) begin
    if (pix_fire && pix_row_q < RowW'(RowsKept)) begin
      rowbuf_q[wslot_q][pix_col_q] <= pix_data_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
